// File: rtl/mem_pkg.sv
// mem_pkg -- shared types and default sizes for pipelined_memory.
//
// Contents:
//   state_t          : DM clear FSM state (CLEAR, READY)
//   DEF_PMA_SIZE     : default program-memory address width
//   DEF_PMD_SIZE     : default program-memory word width
//   DEF_DMA_SIZE     : default data-memory address width
//   DEF_DMD_SIZE     : default data-memory word width
//   dm_depth()       : number of DM words for a given address width
package mem_pkg;

   typedef enum logic {
      CLEAR = 1'b0,   // sweeping zeros through the DM array
      READY = 1'b1    // DM open for requests
   } state_t;

   localparam int DEF_PMA_SIZE = 16;
   localparam int DEF_PMD_SIZE = 32;
   localparam int DEF_DMA_SIZE = 10;
   localparam int DEF_DMD_SIZE = 16;

   function automatic int dm_depth(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

// File: rtl/pipelined_memory_dm_bank.sv
// dm_bank -- data-memory array with a one-entry write latch and read mux.
//
// Writes are split across two edges: the request edge captures the address
// into the latch, the following edge samples wr_data and commits it. A read
// issued on the commit edge to the latched address sees either the incoming
// wr_data (bypass built) or the old array word (bypass not built).
//
// Build option: define PIPELINED_MEMORY_DM_BYPASS_EN to forward the pending
// write data to a same-address read in the commit cycle.
//
// Ports:
//   clk       in  : clock, rising edge
//   reset     in  : asynchronous active-high reset (drops pending write)
//   clr_en    in  : write zero to clr_addr this edge (clear sweep)
//   clr_addr  in  : word being cleared
//   rd_en     in  : read strobe, already qualified by the caller
//   wr_en     in  : write request strobe, already qualified by the caller
//   addr      in  : request address (read or write)
//   wr_data   in  : write data, sampled on the edge after wr_en
//   rd_data   out : registered read data, holds between reads
//   rd_vld    out : rd_data was updated on the last edge
module dm_bank #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              clr_en,
   input  logic [ADDR_W-1:0] clr_addr,
   input  logic              rd_en,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_vld
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   logic              pend_vld;
   logic [ADDR_W-1:0] pend_addr;
   logic [DATA_W-1:0] rd_word;

   // Write latch: one entry, refilled every cycle, so back-to-back writes
   // each commit exactly one edge after their request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_vld  <= 1'b0;
         pend_addr <= '0;
      end else begin
         pend_vld <= wr_en;
         if (wr_en) begin
            pend_addr <= addr;
         end
      end
   end

   // Array port. The clear sweep and pending writes never overlap in
   // normal operation (requests are blocked while clearing); clear wins
   // if they ever did.
   always_ff @(posedge clk) begin
      if (clr_en) begin
         mem[clr_addr] <= '0;
      end else if (pend_vld) begin
         mem[pend_addr] <= wr_data;
      end
   end

   always_comb begin
      rd_word = mem[addr];
`ifdef PIPELINED_MEMORY_DM_BYPASS_EN
      if (pend_vld && (pend_addr == addr)) begin
         rd_word = wr_data;
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data <= '0;
         rd_vld  <= 1'b0;
      end else begin
         rd_vld <= rd_en;
         if (rd_en) begin
            rd_data <= rd_word;
         end
      end
   end

endmodule

// File: rtl/pipelined_memory.sv
// pipelined_memory -- program memory (PM) plus data memory (DM) with a
// self-clearing DM after reset.
//
// Request/response semantics (both memories): a request is a chip select
// sampled high on a rising edge; wrb selects write (1) or read (0). A read
// returns its data on the following edge with the matching *_vld high for
// exactly that one cycle; when no read completes, *_vld is 0 and the data
// output holds its last value. There is no back-pressure: every accepted
// request completes. DM requests are ignored (not accepted) while mem_busy
// is high; PM is always accepted.
//
// Build option: PIPELINED_MEMORY_DM_BYPASS_EN (see dm_bank).
//
// Ports:
//   clk         in  : clock, rising edge
//   reset       in  : asynchronous active-high reset
//   ps_pm_cslt  in  : PM chip select
//   ps_pm_wrb   in  : PM write (1) / read (0)
//   ps_pm_add   in  : PM address
//   ps_pm_dt    in  : PM write data (same edge as request)
//   ps_dm_cslt  in  : DM chip select
//   ps_dm_wrb   in  : DM write (1) / read (0)
//   dg_dm_add   in  : DM address
//   bc_dt       in  : DM write data, sampled one edge after the request
//   pm_ps_op    out : registered PM read data
//   pm_ps_vld   out : pm_ps_op updated on the last edge
//   dm_bc_dt    out : registered DM read data
//   dm_bc_vld   out : dm_bc_dt updated on the last edge
//   mem_busy    out : DM clear sweep in progress
//   fsm_state   out : clear FSM state (observation)
//   clr_cnt     out : clear sweep word index (observation)
module pipelined_memory
   import mem_pkg::*;
#(
   parameter int PMA_SIZE = DEF_PMA_SIZE,
   parameter int PMD_SIZE = DEF_PMD_SIZE,
   parameter int DMA_SIZE = DEF_DMA_SIZE,
   parameter int DMD_SIZE = DEF_DMD_SIZE
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                ps_pm_cslt,
   input  logic                ps_pm_wrb,
   input  logic [PMA_SIZE-1:0] ps_pm_add,
   input  logic [PMD_SIZE-1:0] ps_pm_dt,
   input  logic                ps_dm_cslt,
   input  logic                ps_dm_wrb,
   input  logic [DMA_SIZE-1:0] dg_dm_add,
   input  logic [DMD_SIZE-1:0] bc_dt,
   output logic [PMD_SIZE-1:0] pm_ps_op,
   output logic                pm_ps_vld,
   output logic [DMD_SIZE-1:0] dm_bc_dt,
   output logic                dm_bc_vld,
   output logic                mem_busy,
   output state_t              fsm_state,
   output logic [DMA_SIZE-1:0] clr_cnt
);

   // ------------------------------------------------------------------
   // Program memory: not touched by reset, only by writes or preload.
   // ------------------------------------------------------------------
   logic [PMD_SIZE-1:0] pm_mem [2**PMA_SIZE];
   logic                pm_rd;
   logic                pm_wr;

   assign pm_rd = ps_pm_cslt & ~ps_pm_wrb;
   assign pm_wr = ps_pm_cslt &  ps_pm_wrb;

   always_ff @(posedge clk) begin
      if (pm_wr) begin
         pm_mem[ps_pm_add] <= ps_pm_dt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pm_ps_op  <= '0;
         pm_ps_vld <= 1'b0;
      end else begin
         pm_ps_vld <= pm_rd;
         if (pm_rd) begin
            pm_ps_op <= pm_mem[ps_pm_add];
         end
      end
   end

   // ------------------------------------------------------------------
   // DM clear FSM: one word per cycle from 0 up to the last word, then
   // READY. The last word is cleared on the same edge that enters READY.
   // ------------------------------------------------------------------
   state_t              state;
   state_t              state_next;
   logic [DMA_SIZE-1:0] clr_cnt_q;
   logic [DMA_SIZE-1:0] clr_cnt_next;
   logic                busy;
   logic                clr_en;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= CLEAR;
         clr_cnt_q <= '0;
      end else begin
         state     <= state_next;
         clr_cnt_q <= clr_cnt_next;
      end
   end

   always_comb begin
      state_next   = state;
      clr_cnt_next = clr_cnt_q;
      busy         = 1'b0;
      clr_en       = 1'b0;
      case (state)
         CLEAR: begin
            busy         = 1'b1;
            clr_en       = 1'b1;
            clr_cnt_next = clr_cnt_q + 1'b1;
            if (clr_cnt_q == {DMA_SIZE{1'b1}}) begin
               state_next = READY;
            end
         end
         READY: begin
            busy = 1'b0;
         end
         default: begin
            state_next = CLEAR;
         end
      endcase
   end

   assign mem_busy  = busy;
   assign fsm_state = state;
   assign clr_cnt   = clr_cnt_q;

   // ------------------------------------------------------------------
   // Data memory: requests gated off entirely during the clear sweep.
   // ------------------------------------------------------------------
   logic dm_rd;
   logic dm_wr;

   assign dm_rd = ps_dm_cslt & ~ps_dm_wrb & ~busy;
   assign dm_wr = ps_dm_cslt &  ps_dm_wrb & ~busy;

   dm_bank #(
      .ADDR_W (DMA_SIZE),
      .DATA_W (DMD_SIZE)
   ) u_dm_bank (
      .clk      (clk),
      .reset    (reset),
      .clr_en   (clr_en),
      .clr_addr (clr_cnt_q),
      .rd_en    (dm_rd),
      .wr_en    (dm_wr),
      .addr     (dg_dm_add),
      .wr_data  (bc_dt),
      .rd_data  (dm_bc_dt),
      .rd_vld   (dm_bc_vld)
   );

endmodule

// File: tb/tb_pipelined_memory.sv
// tb_pipelined_memory -- bench for pipelined_memory with a 16-word DM.
// Honours PIPELINED_MEMORY_DM_BYPASS_EN for the same-address commit-cycle read.
module tb_pipelined_memory;
   import mem_pkg::*;

   localparam int PMA = 16;
   localparam int PMD = 32;
   localparam int DMA = 4;
   localparam int DMD = 16;
   localparam int DM_DEPTH = 16;

`ifdef PIPELINED_MEMORY_DM_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif
   localparam logic [15:0] BYP_5 = BYPASS ? 16'h1234 : 16'h0000;

   // ---------------- clock / reset ----------------
   logic           clk;
   logic           reset;
   logic           ps_pm_cslt;
   logic           ps_pm_wrb;
   logic [PMA-1:0] ps_pm_add;
   logic [PMD-1:0] ps_pm_dt;
   logic           ps_dm_cslt;
   logic           ps_dm_wrb;
   logic [DMA-1:0] dg_dm_add;
   logic [DMD-1:0] bc_dt;
   logic [PMD-1:0] pm_ps_op;
   logic           pm_ps_vld;
   logic [DMD-1:0] dm_bc_dt;
   logic           dm_bc_vld;
   logic           mem_busy;
   state_t         fsm_state;
   logic [DMA-1:0] clr_cnt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   pipelined_memory #(
      .PMA_SIZE (PMA),
      .PMD_SIZE (PMD),
      .DMA_SIZE (DMA),
      .DMD_SIZE (DMD)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ps_pm_cslt (ps_pm_cslt),
      .ps_pm_wrb  (ps_pm_wrb),
      .ps_pm_add  (ps_pm_add),
      .ps_pm_dt   (ps_pm_dt),
      .ps_dm_cslt (ps_dm_cslt),
      .ps_dm_wrb  (ps_dm_wrb),
      .dg_dm_add  (dg_dm_add),
      .bc_dt      (bc_dt),
      .pm_ps_op   (pm_ps_op),
      .pm_ps_vld  (pm_ps_vld),
      .dm_bc_dt   (dm_bc_dt),
      .dm_bc_vld  (dm_bc_vld),
      .mem_busy   (mem_busy),
      .fsm_state  (fsm_state),
      .clr_cnt    (clr_cnt)
   );

   // ---------------- bookkeeping ----------------
   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Behavioural view: DM is a plain array that reads as all-zero once the
   // post-reset sweep of DM_DEPTH cycles is over; a write's data arrives on
   // the cycle after its request and lands in the array then.
   int          clear_left;
   logic [15:0] dm_m [DM_DEPTH];
   logic [31:0] pm_m [logic [15:0]];
   bit          pend_v;
   logic [3:0]  pend_a;
   logic [31:0] exp_pm_op;
   bit          exp_pm_vld;
   logic [15:0] exp_dm_dt;
   bit          exp_dm_vld;
   logic [DMD-1:0] exp_q[$];

   // ---------------- driver tasks ----------------
   // Called at a falling edge; drives one cycle, steps the model, samples
   // after the following falling edge.
   task automatic step(input bit pcs, input bit pwr, input logic [15:0] pa,
                       input logic [31:0] pd, input bit dcs, input bit dwr,
                       input logic [3:0] da, input logic [15:0] bd);
      bit          busy_m;
      bit          rd;
      bit          wr;
      logic [15:0] val;
      ps_pm_cslt = pcs;
      ps_pm_wrb  = pwr;
      ps_pm_add  = pa;
      ps_pm_dt   = pd;
      ps_dm_cslt = dcs;
      ps_dm_wrb  = dwr;
      dg_dm_add  = da;
      bc_dt      = bd;

      busy_m = (clear_left > 0);
      check("mem_busy", {63'd0, mem_busy}, {63'd0, busy_m});

      rd = dcs && !dwr && !busy_m;
      wr = dcs &&  dwr && !busy_m;
      if (rd) begin
         val = dm_m[da];
         if (pend_v && pend_a == da && BYPASS) val = bd;
         exp_dm_dt = val;
         exp_q.push_back(val);
      end
      exp_dm_vld = rd;
      if (pend_v) dm_m[pend_a] = bd;
      pend_v = wr;
      pend_a = da;
      if (clear_left > 0) clear_left--;

      exp_pm_vld = pcs && !pwr;
      if (pcs && pwr) pm_m[pa] = pd;
      if (pcs && !pwr) exp_pm_op = pm_m.exists(pa) ? pm_m[pa] : 32'h0;

      @(posedge clk);
      @(negedge clk);

      check("pm_vld", {63'd0, pm_ps_vld}, {63'd0, exp_pm_vld});
      check("pm_op", {32'd0, pm_ps_op}, {32'd0, exp_pm_op});
      check("dm_vld", {63'd0, dm_bc_vld}, {63'd0, exp_dm_vld});
      check("dm_dt", {48'd0, dm_bc_dt}, {48'd0, exp_dm_dt});
      if (dm_bc_vld) begin
         if (exp_q.size() > 0) begin
            check("dm_scoreboard", {48'd0, dm_bc_dt}, {48'd0, exp_q.pop_front()});
         end else begin
            tests++;
            fails++;
            $display("FAIL dm_scoreboard: got dm_bc_vld=1 expected no read outstanding");
         end
      end
   endtask

   task automatic idle(input logic [15:0] bd);
      step(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 4'h0, bd);
   endtask

   task automatic dm_read(input logic [3:0] a);
      step(1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, a, 16'h0);
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      ps_pm_cslt = 1'b0;
      ps_pm_wrb  = 1'b0;
      ps_dm_cslt = 1'b0;
      ps_dm_wrb  = 1'b0;
      #1;
      check("rst_pm_op_async", {32'd0, pm_ps_op}, 64'd0);
      check("rst_dm_dt_async", {48'd0, dm_bc_dt}, 64'd0);
      check("rst_busy_async", {63'd0, mem_busy}, 64'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_pm_op", {32'd0, pm_ps_op}, 64'd0);
      check("rst_pm_vld", {63'd0, pm_ps_vld}, 64'd0);
      check("rst_dm_dt", {48'd0, dm_bc_dt}, 64'd0);
      check("rst_dm_vld", {63'd0, dm_bc_vld}, 64'd0);
      check("rst_busy", {63'd0, mem_busy}, 64'd1);
      check("rst_state", {63'd0, fsm_state}, {63'd0, CLEAR});
      check("rst_clr_cnt", {60'd0, clr_cnt}, 64'd0);
      exp_pm_op  = '0;
      exp_pm_vld = 1'b0;
      exp_dm_dt  = '0;
      exp_dm_vld = 1'b0;
      pend_v     = 1'b0;
      exp_q.delete();
      for (int i = 0; i < DM_DEPTH; i++) dm_m[i] = '0;
      clear_left = DM_DEPTH;
      reset = 1'b0;
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      bit          pcs;
      bit          pwr;
      logic [15:0] pa;
      logic [31:0] pd;
      bit          dcs;
      bit          dwr;
      logic [3:0]  da;
      logic [15:0] bd;
      bit          e_pv;
      logic [31:0] e_po;
      bit          e_dv;
      logic [15:0] e_dd;
   } vec_t;

   vec_t vt [15];

   initial begin
      int busy_n;
      reset      = 1'b1;
      ps_pm_cslt = 1'b0;
      ps_pm_wrb  = 1'b0;
      ps_pm_add  = '0;
      ps_pm_dt   = '0;
      ps_dm_cslt = 1'b0;
      ps_dm_wrb  = 1'b0;
      dg_dm_add  = '0;
      bc_dt      = '0;
      clear_left = 0;

      //            pcs   pwr   pa        pd            dcs   dwr   da    bd        e_pv  e_po          e_dv  e_dd
      vt[0]  = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 1'b1, 4'hA, 16'h0000, 1'b0, 32'hCAFEF00D, 1'b0, 16'h0000};
      vt[1]  = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0, 4'h0, 16'hFFEE, 1'b0, 32'hCAFEF00D, 1'b0, 16'h0000};
      vt[2]  = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 1'b0, 4'hA, 16'h0000, 1'b0, 32'hCAFEF00D, 1'b1, 16'hFFEE};
      vt[3]  = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 1'b1, 4'h5, 16'h0000, 1'b0, 32'hCAFEF00D, 1'b0, 16'hFFEE};
      vt[4]  = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 1'b0, 4'h5, 16'h1234, 1'b0, 32'hCAFEF00D, 1'b1, BYP_5};
      vt[5]  = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 1'b0, 4'h5, 16'h0000, 1'b0, 32'hCAFEF00D, 1'b1, 16'h1234};
      vt[6]  = '{1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 32'hCAFEF00D, 1'b0, 16'h1234};
      vt[7]  = '{1'b1, 1'b0, 16'h0010, 32'h0,        1'b1, 1'b0, 4'hA, 16'h0000, 1'b1, 32'hDEADBEEF, 1'b1, 16'hFFEE};
      vt[8]  = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 32'hDEADBEEF, 1'b0, 16'hFFEE};
      vt[9]  = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 1'b1, 4'h1, 16'h0000, 1'b0, 32'hDEADBEEF, 1'b0, 16'hFFEE};
      vt[10] = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 1'b1, 4'h2, 16'h1111, 1'b0, 32'hDEADBEEF, 1'b0, 16'hFFEE};
      vt[11] = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0, 4'h0, 16'h2222, 1'b0, 32'hDEADBEEF, 1'b0, 16'hFFEE};
      vt[12] = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 1'b0, 4'h1, 16'h0000, 1'b0, 32'hDEADBEEF, 1'b1, 16'h1111};
      vt[13] = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 1'b0, 4'h2, 16'h0000, 1'b0, 32'hDEADBEEF, 1'b1, 16'h2222};
      vt[14] = '{1'b1, 1'b0, 16'h0003, 32'h0,        1'b1, 1'b0, 4'h2, 16'h0000, 1'b1, 32'hCAFEF00D, 1'b1, 16'h2222};

      do_reset();

      // Clear window: DM reads of 0x3 every cycle must be ignored, a write
      // attempted on the last busy cycle must not be latched, PM must work.
      for (int i = 0; i < DM_DEPTH; i++) begin
         if (i == 0)
            step(1'b1, 1'b1, 16'h0003, 32'hCAFEF00D, 1'b1, 1'b0, 4'h3, 16'h0);
         else if (i == 1)
            step(1'b1, 1'b0, 16'h0003, 32'h0, 1'b1, 1'b0, 4'h3, 16'h0);
         else if (i == DM_DEPTH - 1)
            step(1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b1, 4'h3, 16'h0);
         else
            step(1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 4'h3, 16'h0);
         check("busy_read_ignored", {63'd0, dm_bc_vld}, 64'd0);
      end
      idle(16'hBEEF);

      // Whole DM reads back as zero after the sweep.
      for (int a = 0; a < DM_DEPTH; a++) begin
         dm_read(4'(a));
         check("clear_readback", {47'd0, dm_bc_vld, dm_bc_dt}, 64'h1_0000);
      end

      // Directed table.
      for (int i = 0; i < 15; i++) begin
         step(vt[i].pcs, vt[i].pwr, vt[i].pa, vt[i].pd,
              vt[i].dcs, vt[i].dwr, vt[i].da, vt[i].bd);
         check($sformatf("vec%0d_pm_vld", i), {63'd0, pm_ps_vld}, {63'd0, vt[i].e_pv});
         check($sformatf("vec%0d_pm_op", i),  {32'd0, pm_ps_op},  {32'd0, vt[i].e_po});
         check($sformatf("vec%0d_dm_vld", i), {63'd0, dm_bc_vld}, {63'd0, vt[i].e_dv});
         check($sformatf("vec%0d_dm_dt", i),  {48'd0, dm_bc_dt},  {48'd0, vt[i].e_dd});
      end

      // Random traffic against the model; PM confined to preloaded words.
      for (int a = 0; a < 16; a++)
         step(1'b1, 1'b1, 16'h0020 + 16'(a), $urandom, 1'b0, 1'b0, 4'h0, 16'h0);
      for (int n = 0; n < 400; n++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              16'h0020 + 16'($urandom_range(0, 15)), $urandom,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), 16'($urandom));

      // Write in flight when reset hits: it must never land.
      step(1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b1, 4'h7, 16'h0);
      bc_dt = 16'h5A5A;
      do_reset();

      // Reset again mid-sweep at clr_cnt = 7: sweep restarts from word 0.
      repeat (7) idle(16'h0);
      check("clr_cnt_mid", {60'd0, clr_cnt}, 64'd7);
      do_reset();
      busy_n = 0;
      for (int n = 0; n < DM_DEPTH + 4; n++) begin
         if (mem_busy) busy_n++;
         idle(16'h5A5A);
      end
      check("busy_cycles_after_restart", 64'(busy_n), 64'(DM_DEPTH));
      for (int a = 0; a < DM_DEPTH; a++) begin
         dm_read(4'(a));
         check("restart_readback", {47'd0, dm_bc_vld, dm_bc_dt}, 64'h1_0000);
      end

      // PM contents survive reset.
      step(1'b1, 1'b0, 16'h0010, 32'h0, 1'b0, 1'b0, 4'h0, 16'h0);
      check("pm_survives_reset", {32'd0, pm_ps_op}, 64'hDEADBEEF);

      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
